// File: rtl/barrel_shift_pkg.sv
// barrel_shift_pkg: shift-mode encodings and the width legality check shared by the shifter.
package barrel_shift_pkg;
    localparam logic [1:0] MODE_LSL = 2'b00;
    localparam logic [1:0] MODE_LSR = 2'b01;
    localparam logic [1:0] MODE_ASR = 2'b10;
    localparam logic [1:0] MODE_ROL = 2'b11;

    function automatic bit width_ok(input int w);
        return w >= 2 && (w & (w - 1)) == 0;
    endfunction
endpackage

// File: rtl/barrel_shift_stage.sv
// barrel_shift_stage: conditional shift by 2**STAGE followed by the stage register.
module barrel_shift_stage
    import barrel_shift_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int TAG_W = 4,
    parameter int STAGE = 0,
    localparam int SHW = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_data,
    input  logic [SHW-1:0]   in_amt,
    input  logic [1:0]       in_mode,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_data,
    output logic [SHW-1:0]   out_amt,
    output logic [1:0]       out_mode,
    output logic [TAG_W-1:0] out_tag
);
    localparam int S = 1 << STAGE;

    logic [WIDTH-1:0] asr;
    logic [WIDTH-1:0] shifted;

    // Kept apart from the mux so the unsigned mux arms cannot turn >>> into a logical shift.
    always_comb asr = $signed(in_data) >>> S;

    always_comb
        shifted = !in_amt[STAGE]         ? in_data :
                  (in_mode == MODE_LSL)  ? in_data << S :
                  (in_mode == MODE_LSR)  ? in_data >> S :
                  (in_mode == MODE_ASR)  ? asr :
                                           (in_data << S) | (in_data >> (WIDTH - S));

    always_ff @(posedge clk) begin
        if (!rst) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_amt   <= '0;
            out_mode  <= '0;
            out_tag   <= '0;
        end else if (en) begin
            out_valid <= in_valid;
            out_data  <= shifted;
            out_amt   <= in_amt;
            out_mode  <= in_mode;
            out_tag   <= in_tag;
        end
    end
endmodule

// File: rtl/pipelined_barrel_shifter.sv
// pipelined_barrel_shifter: log2(WIDTH)-stage shifter (LSL/LSR/ASR/ROL) with a global-stall handshake.
module pipelined_barrel_shifter
    import barrel_shift_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int TAG_W = 4,
    localparam int SHW = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic [SHW-1:0]   in_amt,
    input  logic [1:0]       in_mode,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic [TAG_W-1:0] out_tag
);
    if (!width_ok(WIDTH) || TAG_W < 1) begin : g_bad_params
        $error("pipelined_barrel_shifter: WIDTH must be a power of two >= 2 and TAG_W >= 1");
    end

    logic             en;
    logic             v [SHW+1];
    logic [WIDTH-1:0] d [SHW+1];
    logic [SHW-1:0]   a [SHW+1];
    logic [1:0]       m [SHW+1];
    logic [TAG_W-1:0] t [SHW+1];

    // The whole pipe moves together; it only freezes when the output is held.
    assign en       = out_ready | ~out_valid;
    assign in_ready = en;

    assign v[0] = in_valid;
    assign d[0] = in_data;
    assign a[0] = in_amt;
    assign m[0] = in_mode;
    assign t[0] = in_tag;

    for (genvar k = 0; k < SHW; k++) begin : g_stage
        barrel_shift_stage #(.WIDTH(WIDTH), .TAG_W(TAG_W), .STAGE(k)) u_stage (
            .clk      (clk),
            .rst      (rst),
            .en       (en),
            .in_valid (v[k]),
            .in_data  (d[k]),
            .in_amt   (a[k]),
            .in_mode  (m[k]),
            .in_tag   (t[k]),
            .out_valid(v[k+1]),
            .out_data (d[k+1]),
            .out_amt  (a[k+1]),
            .out_mode (m[k+1]),
            .out_tag  (t[k+1])
        );
    end

    assign out_valid = v[SHW];
    assign out_data  = d[SHW];
    assign out_tag   = t[SHW];
endmodule
